// File: rtl/carry_chain_seq_ctrl.sv
// Sequencer that computes a WIDTH-bit add by driving one external 4-bit carry-chain
// adder a slice per cycle (LSB first), registering the inter-slice carry.
module carry_chain_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [1:0]       dbg_state
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and out_sum/out_cout
  // stay stable until out_ready is seen.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  work_reg;
  logic [WIDTH-1:0]  sum_merged;
  logic [WIDTH-1:0]  out_sum_reg;
  logic              out_cout_reg;
  logic              carry_reg;
  logic              accept;
  logic              last_slice;

  assign in_ready   = (state == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign last_slice = (idx == IDXW'(NSLICE - 1));
  assign out_valid  = (state == DONE);
  assign out_sum    = out_sum_reg;
  assign out_cout   = out_cout_reg;
  assign dbg_state  = state;

  always_comb begin
    state_next = state;
    add_a      = 4'd0;
    add_b      = 4'd0;
    add_cin    = 1'b0;
    sum_merged = work_reg;
    case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN: begin
        add_a   = a_reg[4*idx +: 4];
        add_b   = b_reg[4*idx +: 4];
        add_cin = carry_reg;
        sum_merged[4*idx +: 4] = add_sum;
        if (last_slice) state_next = DONE;
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // out_sum/out_cout live in their own registers so they stay put while the next
  // operation is being assembled in work_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      carry_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      work_reg     <= '0;
      out_sum_reg  <= '0;
      out_cout_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_reg     <= in_a;
        b_reg     <= in_b;
        carry_reg <= in_cin;
        idx       <= '0;
      end else if (state == RUN) begin
        work_reg  <= sum_merged;
        carry_reg <= add_cout;
        if (last_slice) begin
          out_sum_reg  <= sum_merged;
          out_cout_reg <= add_cout;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_carry_chain_seq_ctrl.sv
// Directed bench for carry_chain_seq_ctrl (WIDTH=16) with a behavioural 4-bit adder
// on the add_* ports.
module tb_carry_chain_seq_ctrl;

  localparam int WIDTH = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];

  carry_chain_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .dbg_state(dbg_state)
  );

  // external 4-bit carry-chain adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: wait (bounded) for in_ready, then present one operand set for one edge
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL issue_wait in_ready=%0b required 1", in_ready);
    end
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    checks++;
    if ({out_cout, out_sum} !== 17'd0) begin errors++; $display("FAIL rst_out got %h want 0", {out_cout, out_sum}); end
    checks++;
    if ({add_a, add_b, add_cin} !== 9'd0) begin errors++; $display("FAIL rst_add got %h want 0", {add_a, add_b, add_cin}); end
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_state got %0d want 0", dbg_state); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_zero();
    issue(16'h0000, 16'h0000, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_early_valid cycle %0d got %0b want 0", i, out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready cycle %0d got %0b want 0", i, in_ready); end
      step();
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid_cycle5 got %0b want 1", out_valid); end
    checks++;
    if ({out_cout, out_sum} !== 17'h0_0000) begin errors++; $display("FAIL zero_sum got %h want 00000", {out_cout, out_sum}); end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_release valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_carry();
    logic exp_cin[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    issue(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (add_cin !== exp_cin[i]) begin errors++; $display("FAIL carry_add_cin slice %0d got %0b want %0b", i, add_cin, exp_cin[i]); end
      step();
    end
    checks++;
    if (add_cin !== 1'b0) begin errors++; $display("FAIL carry_add_cin_done got %0b want 0", add_cin); end
    checks++;
    if (out_sum !== 16'h0000 || out_cout !== 1'b1) begin
      errors++; $display("FAIL carry_sum got %h/%0b want 0000/1", out_sum, out_cout);
    end
    release_result();
  endtask

  task automatic test_mixed();
    logic [3:0] exp_a[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] exp_b[4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    issue(16'h1234, 16'h4321, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (add_a !== exp_a[i] || add_b !== exp_b[i]) begin
        errors++; $display("FAIL mixed_slices slice %0d got %h/%h want %h/%h", i, add_a, add_b, exp_a[i], exp_b[i]);
      end
      step();
    end
    checks++;
    if (out_sum !== 16'h5556 || out_cout !== 1'b0) begin
      errors++; $display("FAIL mixed_sum got %h/%0b want 5556/0", out_sum, out_cout);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    issue(16'h00FF, 16'h0F01, 1'b0);
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_flags cycle %0d valid=%0b ready=%0b want 1/0", i, out_valid, in_ready);
      end
      checks++;
      if (out_sum !== 16'h1000 || out_cout !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got %h/%0b want 1000/0", i, out_sum, out_cout);
      end
      step();
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL bp_release valid=%0b state=%0d want 0/0", out_valid, dbg_state);
    end
    step();
    checks++;
    if (dbg_state !== S_IDLE || out_sum !== 16'h1000) begin
      errors++; $display("FAIL bp_no_latch state=%0d sum=%h want 0/1000", dbg_state, out_sum);
    end
  endtask

  task automatic test_abort();
    issue(16'hAAAA, 16'h5555, 1'b0);
    step();
    step();
    checks++;
    if (dbg_state !== S_RUN || add_a !== 4'hA) begin
      errors++; $display("FAIL abort_pre state=%0d add_a=%h want 1/a", dbg_state, add_a);
    end
    rst = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL abort_rst ready=%0b state=%0d want 0/0", in_ready, dbg_state);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL abort_quiet cycle %0d valid=%0b ready=%0b want 0/1", i, out_valid, in_ready);
      end
      step();
    end
    issue(16'h8000, 16'h8000, 1'b0);
    repeat (4) step();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0000 || out_cout !== 1'b1) begin
      errors++; $display("FAIL abort_next valid=%0b got %h/%0b want 1 0000/1", out_valid, out_sum, out_cout);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH:0] exp;
    logic           accepted;
    int n_acc, n_res, cyc, last_acc;
    n_acc = 0; n_res = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1;
    in_a = WIDTH'($urandom_range(0, 65535));
    in_b = WIDTH'($urandom_range(0, 65535));
    in_cin = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    while ((n_acc < 200 || n_res < 200) && cyc < 2000) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got %h want none", {out_cout, out_sum});
        end else begin
          exp = exp_q.pop_front();
          if ({out_cout, out_sum} !== exp) begin
            errors++; $display("FAIL b2b_sum result %0d got %h want %h", n_res, {out_cout, out_sum}, exp);
          end
        end
        n_res++;
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + {16'd0, in_cin});
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 6) begin
            errors++; $display("FAIL b2b_spacing accept %0d got %0d want 6", n_acc, cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
      step();
      cyc++;
      if (accepted) begin
        if (n_acc < 200) begin
          in_a = WIDTH'($urandom_range(0, 65535));
          in_b = WIDTH'($urandom_range(0, 65535));
          in_cin = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (n_acc != 200 || n_res != 200 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count acc=%0d res=%0d pending=%0d want 200/200/0", n_acc, n_res, exp_q.size());
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_carry();
    test_mixed();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
